// File: rtl/csr_ctrl_pkg.sv
// Shared types and address-map helpers for the APB CSR control block.
// Optional feature macro: CSR_ERR_CNT_EN (error completion counter).
package csr_ctrl_pkg;

   // APB slave FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_WAIT   = 2'd3
   } state_t;

   // Decoded register target of a transfer
   typedef enum logic [2:0] {
      TGT_NONE   = 3'd0,
      TGT_CTRL   = 3'd1,
      TGT_DATA   = 3'd2,
      TGT_RES    = 3'd3,
      TGT_STATUS = 3'd4,
      TGT_ERRCNT = 3'd5
   } target_t;

   // Opcodes accepted by a CTRL write
   localparam int unsigned OP_LEGAL_A = 32'd1;
   localparam int unsigned OP_LEGAL_B = 32'd2;

   // Saturation value of the error counter
   localparam logic [7:0] ERRCNT_MAX = 8'd255;

   function automatic int unsigned ctrl_offset();
      return 32'd0;
   endfunction

   // Operand register i (0-based) sits just after CTRL
   function automatic int unsigned data_offset(input int unsigned i);
      return i + 32'd1;
   endfunction

   function automatic int unsigned last_data_offset(input int unsigned nd);
      return nd;
   endfunction

   function automatic int unsigned res_offset(input int unsigned nd);
      return nd + 32'd1;
   endfunction

   function automatic int unsigned status_offset(input int unsigned nd);
      return nd + 32'd2;
   endfunction

   function automatic int unsigned errcnt_offset(input int unsigned nd);
      return nd + 32'd3;
   endfunction

endpackage

// File: rtl/csr_err_decode.sv
// Combinational address decode and error classification for one APB transfer.
// The ERRCNT register only decodes when CSR_ERR_CNT_EN is defined; otherwise
// its address falls into the out-of-range error class.
module csr_err_decode
   import csr_ctrl_pkg::*;
#(
   parameter int NUM_DATA       = 2,
   parameter int OPERATION_SIZE = 2,
   parameter int ADDR_W         = $clog2(NUM_DATA + 4)
) (
   input  logic [ADDR_W-1:0]         paddr,
   input  logic                      pwrite,
   input  logic [OPERATION_SIZE-1:0] ctrl_op,
   input  logic                      full_in,
   input  logic                      empty_out,
   output target_t                   target,
   output logic [NUM_DATA-1:0]       data_sel,
   output logic                      err
);

   logic [31:0] addr;
   logic [31:0] op;

   assign addr = 32'(paddr);
   assign op   = 32'(ctrl_op);

   // Map the address onto a register target and a one-hot operand select
   always_comb begin
      target   = TGT_NONE;
      data_sel = {NUM_DATA{1'b0}};
      if (addr == ctrl_offset()) begin
         target = TGT_CTRL;
      end else if (addr <= last_data_offset(NUM_DATA)) begin
         target = TGT_DATA;
      end else if (addr == res_offset(NUM_DATA)) begin
         target = TGT_RES;
      end else if (addr == status_offset(NUM_DATA)) begin
         target = TGT_STATUS;
`ifdef CSR_ERR_CNT_EN
      end else if (addr == errcnt_offset(NUM_DATA)) begin
         target = TGT_ERRCNT;
`endif
      end else begin
         target = TGT_NONE;
      end
      for (int i = 0; i < NUM_DATA; i++) begin
         data_sel[i] = (addr == data_offset(i));
      end
   end

   // Classify direction, FIFO-state and opcode violations for the target
   always_comb begin
      err = 1'b1;
      case (target)
         TGT_CTRL:   err = !pwrite || full_in || !((op == OP_LEGAL_A) || (op == OP_LEGAL_B));
         TGT_DATA:   err = !pwrite || full_in;
         TGT_RES:    err = pwrite || empty_out;
         TGT_STATUS: err = pwrite;
         TGT_ERRCNT: err = pwrite;
         TGT_NONE:   err = 1'b1;
         default:    err = 1'b1;
      endcase
   end

endmodule

// File: rtl/apb_csr_ctrl_mc.sv
// APB slave control for the ALU CS registers and FIFOs: SETUP-phase decode,
// programmable read wait states after the FIFO_OUT pop, write strobes and
// delayed FIFO_IN push. CSR_ERR_CNT_EN adds a saturating error counter.
module apb_csr_ctrl_mc
   import csr_ctrl_pkg::*;
#(
   parameter int NUM_DATA       = 2,
   parameter int OPERATION_SIZE = 2,
   parameter int FIFO_OUT_WIDTH = 25,
   parameter int APB_BUS_SIZE   = 32,
   parameter int RD_WAIT        = 1,
   parameter int ADDR_W         = $clog2(NUM_DATA + 4)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         paddr,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [OPERATION_SIZE-1:0] ctrl_op,
   input  logic                      start_bit,
   input  logic [FIFO_OUT_WIDTH-1:0] final_result,
   input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
   input  logic                      full_in,
   input  logic                      empty_out,
   output logic                      pready,
   output logic                      pslverr,
   output logic [APB_BUS_SIZE-1:0]   prdata,
   output logic                      en_ctrl,
   output logic [NUM_DATA-1:0]       en_data,
   output logic                      r_en_out,
   output logic                      w_en_in
);

   localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

   state_t                    state;
   state_t                    next_state;
   logic [3:0]                cnt;
   logic                      err_q;
   target_t                   target_q;
   logic [NUM_DATA-1:0]       sel_q;
   logic [FIFO_OUT_WIDTH-1:0] res_q;
   logic                      ctrl_done;
   logic                      complete;
   logic                      load_cnt;
   logic                      good;
   target_t                   dec_target;
   logic [NUM_DATA-1:0]       dec_sel;
   logic                      dec_err;
`ifdef CSR_ERR_CNT_EN
   logic [7:0]                errcnt;
`endif

   csr_err_decode #(
      .NUM_DATA       (NUM_DATA),
      .OPERATION_SIZE (OPERATION_SIZE),
      .ADDR_W         (ADDR_W)
   ) u_decode (
      .paddr     (paddr),
      .pwrite    (pwrite),
      .ctrl_op   (ctrl_op),
      .full_in   (full_in),
      .empty_out (empty_out),
      .target    (dec_target),
      .data_sel  (dec_sel),
      .err       (dec_err)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Latch decode in SETUP, run the wait counter, hold popped data, arm the push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q     <= 1'b0;
         target_q  <= TGT_NONE;
         sel_q     <= {NUM_DATA{1'b0}};
         cnt       <= 4'd0;
         res_q     <= {FIFO_OUT_WIDTH{1'b0}};
         ctrl_done <= 1'b0;
      end else begin
         if (state == ST_SETUP) begin
            err_q    <= dec_err;
            target_q <= dec_target;
            sel_q    <= dec_sel;
         end
         if (load_cnt) begin
            cnt <= RD_WAIT_C;
         end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (r_en_out) begin
            res_q <= final_result;
         end
         ctrl_done <= complete && !err_q && (target_q == TGT_CTRL);
      end
   end

`ifdef CSR_ERR_CNT_EN
   // Count error completions, saturating at the maximum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         errcnt <= 8'd0;
      end else if (complete && err_q && (errcnt != ERRCNT_MAX)) begin
         errcnt <= errcnt + 8'd1;
      end
   end
`endif

   // Next-state logic, completion detection and FIFO_OUT pop
   always_comb begin
      next_state = state;
      complete   = 1'b0;
      load_cnt   = 1'b0;
      r_en_out   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               next_state = ST_SETUP;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (!psel) begin
               next_state = ST_IDLE;
            end else if (penable) begin
               next_state = ST_ACCESS;
            end else begin
               next_state = ST_SETUP;
            end
         end
         ST_ACCESS: begin
            if (psel && penable) begin
               if (!err_q && (target_q == TGT_RES)) begin
                  r_en_out = 1'b1;
                  if (RD_WAIT_C == 4'd0) begin
                     complete   = 1'b1;
                     next_state = (psel && !penable) ? ST_SETUP : ST_IDLE;
                  end else begin
                     load_cnt   = 1'b1;
                     next_state = ST_WAIT;
                  end
               end else begin
                  complete   = 1'b1;
                  next_state = (psel && !penable) ? ST_SETUP : ST_IDLE;
               end
            end else if (psel) begin
               next_state = ST_SETUP;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (psel && penable) begin
               // cnt <= 1 rather than == 1 so a corrupted zero count cannot hang the bus
               if (cnt <= 4'd1) begin
                  complete   = 1'b1;
                  next_state = (psel && !penable) ? ST_SETUP : ST_IDLE;
               end else begin
                  next_state = ST_WAIT;
               end
            end else if (psel) begin
               next_state = ST_SETUP;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Completion-cycle responses, write strobes, read data and FIFO_IN push
   always_comb begin
      good    = complete && !err_q;
      pready  = complete;
      pslverr = complete && err_q;
      en_ctrl = good && (target_q == TGT_CTRL);
      en_data = {NUM_DATA{1'b0}};
      prdata  = {APB_BUS_SIZE{1'b0}};
      if (good && (target_q == TGT_DATA)) begin
         en_data = sel_q;
      end else begin
         en_data = {NUM_DATA{1'b0}};
      end
      if (good) begin
         case (target_q)
            // With no wait states the pop and the completion share a cycle
            TGT_RES:    prdata = (state == ST_ACCESS) ? APB_BUS_SIZE'(final_result)
                                                      : APB_BUS_SIZE'(res_q);
            TGT_STATUS: prdata = APB_BUS_SIZE'(fifo_out_status);
`ifdef CSR_ERR_CNT_EN
            TGT_ERRCNT: prdata = APB_BUS_SIZE'(errcnt);
`endif
            default:    prdata = {APB_BUS_SIZE{1'b0}};
         endcase
      end else begin
         prdata = {APB_BUS_SIZE{1'b0}};
      end
      w_en_in = ctrl_done && start_bit;
   end

endmodule
